ysyx_25040129_lsu: RTL and testbench

Load/store stage between EXU and WBU. Accepts one instruction from EXU per valid/ready handshake and performs at most one memory access on a request/response bus. It then presents the writeback packet (rd, result, csr fields) to WBU as the upstream valid/ready initiator. It also drives the LSU-stage forwarding port.

---
 rtl/ysyx_25040129_lsu.sv | 245 ++++++++++++++++++++++++
 tb/tb_ysyx_25040129_lsu.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040129_lsu.sv
// Load/store stage between EXU and WBU.
// Accepts one packet from EXU per valid/ready handshake. Performs at most one access on the
// memory request/response bus. Presents the writeback packet to WBU and drives the LSU-stage
// forwarding port.
// Ports:
//   clock, reset (async, active-low)
//   EXU side : is_req_valid_from_exu / is_req_ready_to_exu plus the *_in_lsu packet fields
//   mem req  : mem_req_valid / mem_req_ready, mem_addr, mem_wen, mem_wdata, mem_wstrb
//   mem rsp  : mem_rsp_valid / mem_rsp_ready, mem_rsp_rdata, mem_rsp_err
//   WBU side : is_req_valid_to_wbu / is_req_ready_from_wbu plus the *_out_lsu fields and lsu_fault
//   forward  : is_data_forward_valid_from_lsu, lsu_forward_data
module ysyx_25040129_lsu #(
    parameter int unsigned REGS_DIG = 5,
    parameter int unsigned CSR_DIG  = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                is_req_valid_from_exu,
    output logic                is_req_ready_to_exu,
    input  logic [REGS_DIG-1:0] rd_in_lsu,
    input  logic [31:0]         result_in_lsu,
    input  logic [31:0]         store_data_in_lsu,
    input  logic                mem_read_in_lsu,
    input  logic                mem_write_in_lsu,
    input  logic [2:0]          funct3_in_lsu,
    input  logic [CSR_DIG-1:0]  csr_addr_in_lsu,
    input  logic                csr_write_in_lsu,
    input  logic                reg_write_in_lsu,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_addr,
    output logic                mem_wen,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [31:0]         mem_rsp_rdata,
    input  logic                mem_rsp_err,
    output logic                is_req_valid_to_wbu,
    input  logic                is_req_ready_from_wbu,
    output logic [REGS_DIG-1:0] rd_out_lsu,
    output logic [31:0]         result_out_lsu,
    output logic [CSR_DIG-1:0]  csr_addr_out_lsu,
    output logic                csr_write_out_lsu,
    output logic                reg_write_out_lsu,
    output logic                lsu_fault,
    output logic                is_data_forward_valid_from_lsu,
    output logic [31:0]         lsu_forward_data
);

    typedef enum logic [1:0] {StIdle, StReq, StRsp, StWb} state_e;

    // Access size: 0 = byte, 1 = halfword, 2 = word. The unsigned load codes only mean a
    // narrow access for loads; any store code other than sb/sh is a full word.
    function automatic logic [1:0] access_size(input logic [2:0] f3, input logic is_load);
        logic [1:0] sz;
        case (f3)
            3'b000:  sz = 2'd0;
            3'b001:  sz = 2'd1;
            3'b100:  sz = is_load ? 2'd0 : 2'd2;
            3'b101:  sz = is_load ? 2'd1 : 2'd2;
            default: sz = 2'd2;
        endcase
        return sz;
    endfunction

    state_e              state_q, state_d;
    logic [REGS_DIG-1:0] rd_q, rd_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         sdata_q, sdata_d;
    logic [31:0]         result_q, result_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [CSR_DIG-1:0]  csr_addr_q, csr_addr_d;
    logic                csr_write_q, csr_write_d;
    logic                reg_write_q, reg_write_d;
    logic                fault_q, fault_d;

    logic        st_req, st_rsp, st_wb;
    logic        accept;
    logic [1:0]  in_size, q_size;
    logic        in_misaligned;
    logic [31:0] lane;
    logic [31:0] load_data;

    assign st_req = (state_q == StReq);
    assign st_rsp = (state_q == StRsp);
    assign st_wb  = (state_q == StWb);

    // Gated with reset so EXU sees "not ready" for the whole time reset is held.
    assign is_req_ready_to_exu = reset & ((state_q == StIdle) | (st_wb & is_req_ready_from_wbu));
    assign accept              = is_req_valid_from_exu & is_req_ready_to_exu;

    assign in_size       = access_size(funct3_in_lsu, mem_read_in_lsu);
    assign in_misaligned = ((in_size == 2'd1) & result_in_lsu[0]) |
                           ((in_size == 2'd2) & (result_in_lsu[1:0] != 2'b00));

    // Load extraction: shift the addressed byte lane down to bit 0, then extend.
    assign lane = mem_rsp_rdata >> {addr_q[1:0], 3'b000};
    always_comb begin
        load_data = mem_rsp_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'b0, lane[7:0]};
            3'b101:  load_data = {16'b0, lane[15:0]};
            default: load_data = mem_rsp_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        result_d    = result_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        funct3_d    = funct3_q;
        csr_addr_d  = csr_addr_q;
        csr_write_d = csr_write_q;
        reg_write_d = reg_write_q;
        fault_d     = fault_q;

        unique case (state_q)
            StIdle: ;
            StReq: begin
                // A response in the handshake cycle is not looked at; only RSP counts.
                if (mem_req_ready) state_d = StRsp;
            end
            StRsp: begin
                if (mem_rsp_valid) begin
                    state_d = StWb;
                    if (mem_read_q) result_d = load_data;
                    if (mem_rsp_err) begin
                        fault_d     = 1'b1;
                        reg_write_d = 1'b0;
                    end
                end
            end
            StWb: begin
                if (is_req_ready_from_wbu) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A new packet overrides the WB->IDLE transition, giving back-to-back throughput.
        if (accept) begin
            rd_d        = rd_in_lsu;
            addr_d      = result_in_lsu;
            sdata_d     = store_data_in_lsu;
            result_d    = result_in_lsu;
            mem_read_d  = mem_read_in_lsu;
            mem_write_d = mem_write_in_lsu;
            funct3_d    = funct3_in_lsu;
            csr_addr_d  = csr_addr_in_lsu;
            csr_write_d = csr_write_in_lsu;
            reg_write_d = reg_write_in_lsu;
            fault_d     = 1'b0;
            if (!(mem_read_in_lsu | mem_write_in_lsu)) begin
                state_d = StWb;
            end else if (in_misaligned) begin
                state_d     = StWb;
                fault_d     = 1'b1;
                reg_write_d = 1'b0;
            end else begin
                state_d = StReq;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rd_q        <= '0;
            addr_q      <= '0;
            sdata_q     <= '0;
            result_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            funct3_q    <= '0;
            csr_addr_q  <= '0;
            csr_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            result_q    <= result_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            funct3_q    <= funct3_d;
            csr_addr_q  <= csr_addr_d;
            csr_write_q <= csr_write_d;
            reg_write_q <= reg_write_d;
            fault_q     <= fault_d;
        end
    end

    // Request fields come straight from the latched packet, so they hold while REQ waits.
    assign q_size = access_size(funct3_q, 1'b0);

    always_comb begin
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (st_req) begin
            mem_addr = {addr_q[31:2], 2'b00};
            mem_wen  = mem_write_q;
            case (q_size)
                2'd0: begin
                    mem_wstrb = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{sdata_q[7:0]}};
                end
                2'd1: begin
                    mem_wstrb = 4'b0011 << addr_q[1:0];
                    mem_wdata = {2{sdata_q[15:0]}};
                end
                default: begin
                    mem_wstrb = 4'b1111;
                    mem_wdata = sdata_q;
                end
            endcase
        end
    end

    assign mem_req_valid       = st_req;
    assign mem_rsp_ready       = st_rsp;
    assign is_req_valid_to_wbu = st_wb;

    assign rd_out_lsu        = rd_q;
    assign result_out_lsu    = result_q;
    assign csr_addr_out_lsu  = csr_addr_q;
    assign csr_write_out_lsu = csr_write_q & st_wb;
    assign reg_write_out_lsu = reg_write_q & st_wb;
    assign lsu_fault         = fault_q & st_wb;

    assign is_data_forward_valid_from_lsu = reg_write_out_lsu;
    assign lsu_forward_data               = result_q;

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// Self-checking bench for ysyx_25040129_lsu: directed test-plan cases followed by randomized
// transactions, all checked against an arithmetic reference model of the LSU rules.
module tb_ysyx_25040129_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        is_req_valid_from_exu;
    logic        is_req_ready_to_exu;
    logic [4:0]  rd_in_lsu;
    logic [31:0] result_in_lsu;
    logic [31:0] store_data_in_lsu;
    logic        mem_read_in_lsu;
    logic        mem_write_in_lsu;
    logic [2:0]  funct3_in_lsu;
    logic [11:0] csr_addr_in_lsu;
    logic        csr_write_in_lsu;
    logic        reg_write_in_lsu;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;
    logic        is_req_valid_to_wbu;
    logic        is_req_ready_from_wbu;
    logic [4:0]  rd_out_lsu;
    logic [31:0] result_out_lsu;
    logic [11:0] csr_addr_out_lsu;
    logic        csr_write_out_lsu;
    logic        reg_write_out_lsu;
    logic        lsu_fault;
    logic        is_data_forward_valid_from_lsu;
    logic [31:0] lsu_forward_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    ysyx_25040129_lsu #(.REGS_DIG(5), .CSR_DIG(12)) dut (
        .clock                          (clock),
        .reset                          (reset),
        .is_req_valid_from_exu          (is_req_valid_from_exu),
        .is_req_ready_to_exu            (is_req_ready_to_exu),
        .rd_in_lsu                      (rd_in_lsu),
        .result_in_lsu                  (result_in_lsu),
        .store_data_in_lsu              (store_data_in_lsu),
        .mem_read_in_lsu                (mem_read_in_lsu),
        .mem_write_in_lsu               (mem_write_in_lsu),
        .funct3_in_lsu                  (funct3_in_lsu),
        .csr_addr_in_lsu                (csr_addr_in_lsu),
        .csr_write_in_lsu               (csr_write_in_lsu),
        .reg_write_in_lsu               (reg_write_in_lsu),
        .mem_req_valid                  (mem_req_valid),
        .mem_req_ready                  (mem_req_ready),
        .mem_addr                       (mem_addr),
        .mem_wen                        (mem_wen),
        .mem_wdata                      (mem_wdata),
        .mem_wstrb                      (mem_wstrb),
        .mem_rsp_valid                  (mem_rsp_valid),
        .mem_rsp_ready                  (mem_rsp_ready),
        .mem_rsp_rdata                  (mem_rsp_rdata),
        .mem_rsp_err                    (mem_rsp_err),
        .is_req_valid_to_wbu            (is_req_valid_to_wbu),
        .is_req_ready_from_wbu          (is_req_ready_from_wbu),
        .rd_out_lsu                     (rd_out_lsu),
        .result_out_lsu                 (result_out_lsu),
        .csr_addr_out_lsu               (csr_addr_out_lsu),
        .csr_write_out_lsu              (csr_write_out_lsu),
        .reg_write_out_lsu              (reg_write_out_lsu),
        .lsu_fault                      (lsu_fault),
        .is_data_forward_valid_from_lsu (is_data_forward_valid_from_lsu),
        .lsu_forward_data               (lsu_forward_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] sdata;
        logic        rd_mem;
        logic        wr_mem;
        logic [2:0]  f3;
        logic [11:0] csr;
        logic        csrw;
        logic        regw;
    } txn_t;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned model_size(input logic [2:0] f3, input logic is_load);
        if (f3 == 3'd0 || (is_load && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (is_load && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic logic model_misaligned(input txn_t t);
        int unsigned sz;
        sz = model_size(t.f3, t.rd_mem);
        return (t.rd_mem || t.wr_mem) && ((t.res % sz) != 0);
    endfunction

    function automatic logic [3:0] model_wstrb(input txn_t t);
        int unsigned sz;
        int unsigned off;
        sz  = model_size(t.f3, 1'b0);
        off = (sz == 4) ? 0 : t.res % 4;
        return 4'((((1 << sz) - 1) << off));
    endfunction

    function automatic logic [31:0] model_wdata(input txn_t t);
        int unsigned sz;
        sz = model_size(t.f3, 1'b0);
        if (sz == 1) return (t.sdata & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (t.sdata & 32'hFFFF) * 32'h0001_0001;
        return t.sdata;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [2:0] f3);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = addr % 4;
        b   = (rdata >> (8 * off)) & 32'hFF;
        h   = (rdata >> (8 * off)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    // ---------------- one complete transaction ----------------
    task automatic run_txn(input txn_t t, input int req_wait, input int rsp_wait,
                           input int wb_wait, input logic [31:0] rdata, input logic err,
                           input logic stray, output logic [31:0] obs_res,
                           output logic [3:0] obs_strb, output logic [31:0] obs_wdata);
        logic        mem_exp;
        logic        fault_exp;
        logic [31:0] res_exp;
        mem_exp   = (t.rd_mem || t.wr_mem) && !model_misaligned(t);
        fault_exp = model_misaligned(t) || (mem_exp && err);
        res_exp   = (mem_exp && t.rd_mem) ? model_load(rdata, t.res, t.f3) : t.res;
        obs_strb  = '0;
        obs_wdata = '0;

        @(negedge clock);
        is_req_valid_from_exu = 1'b1;
        rd_in_lsu             = t.rd;
        result_in_lsu         = t.res;
        store_data_in_lsu     = t.sdata;
        mem_read_in_lsu       = t.rd_mem;
        mem_write_in_lsu      = t.wr_mem;
        funct3_in_lsu         = t.f3;
        csr_addr_in_lsu       = t.csr;
        csr_write_in_lsu      = t.csrw;
        reg_write_in_lsu      = t.regw;
        is_req_ready_from_wbu = 1'b0;
        #1 check1("exu_ready_idle", is_req_ready_to_exu, 1'b1);
        @(posedge clock);
        @(negedge clock);
        is_req_valid_from_exu = 1'b0;
        result_in_lsu         = ~t.res;
        store_data_in_lsu     = ~t.sdata;
        #1;
        if (mem_exp) begin
            check1("req_valid", mem_req_valid, 1'b1);
            check32("req_addr", mem_addr, t.res & 32'hFFFF_FFFC);
            check1("req_wen", mem_wen, t.wr_mem);
            if (t.wr_mem) begin
                check32("req_wstrb", 32'(mem_wstrb), 32'(model_wstrb(t)));
                check32("req_wdata", mem_wdata, model_wdata(t));
            end
            obs_strb  = mem_wstrb;
            obs_wdata = mem_wdata;
            for (int i = 0; i < req_wait; i++) begin
                @(negedge clock);
                #1;
                check1("req_hold_valid", mem_req_valid, 1'b1);
                check32("req_hold_addr", mem_addr, t.res & 32'hFFFF_FFFC);
                check32("req_hold_wdata", mem_wdata, obs_wdata);
                check32("req_hold_wstrb", 32'(mem_wstrb), 32'(obs_strb));
            end
            mem_req_ready = 1'b1;
            if (stray) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = ~rdata;
                mem_rsp_err   = 1'b1;
            end
            @(posedge clock);
            @(negedge clock);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            #1;
            check1("rsp_req_drop", mem_req_valid, 1'b0);
            check1("rsp_ready", mem_rsp_ready, 1'b1);
            check1("rsp_no_wb", is_req_valid_to_wbu, 1'b0);
            for (int i = 0; i < rsp_wait; i++) begin
                @(negedge clock);
                #1;
                check1("rsp_wait_ready", mem_rsp_ready, 1'b1);
                check1("rsp_wait_no_wb", is_req_valid_to_wbu, 1'b0);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
            mem_rsp_err   = err;
            @(posedge clock);
            @(negedge clock);
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            #1;
        end else begin
            check1("no_req", mem_req_valid, 1'b0);
        end

        check1("wb_valid", is_req_valid_to_wbu, 1'b1);
        check32("wb_rd", 32'(rd_out_lsu), 32'(t.rd));
        if (!(mem_exp && err)) check32("wb_result", result_out_lsu, res_exp);
        check1("wb_fault", lsu_fault, fault_exp);
        check1("wb_regw", reg_write_out_lsu, t.regw && !fault_exp);
        check32("wb_csr_addr", 32'(csr_addr_out_lsu), 32'(t.csr));
        check1("wb_csrw", csr_write_out_lsu, t.csrw);
        check1("fwd_valid", is_data_forward_valid_from_lsu, t.regw && !fault_exp);
        check32("fwd_data", lsu_forward_data, result_out_lsu);
        check1("wb_exu_blocked", is_req_ready_to_exu, 1'b0);
        obs_res = result_out_lsu;
        for (int i = 0; i < wb_wait; i++) begin
            @(negedge clock);
            #1;
            check1("wb_hold_valid", is_req_valid_to_wbu, 1'b1);
            check32("wb_hold_result", result_out_lsu, obs_res);
            check1("wb_hold_blocked", is_req_ready_to_exu, 1'b0);
        end
        is_req_ready_from_wbu = 1'b1;
        #1 check1("wb_exu_ready", is_req_ready_to_exu, 1'b1);
        @(posedge clock);
        @(negedge clock);
        is_req_ready_from_wbu = 1'b0;
        #1;
        check1("idle_no_wb", is_req_valid_to_wbu, 1'b0);
        check1("idle_regw", reg_write_out_lsu, 1'b0);
    endtask

    function automatic txn_t mk(input logic [4:0] rd, input logic [31:0] res,
                                input logic [31:0] sdata, input logic rdm, input logic wrm,
                                input logic [2:0] f3, input logic regw);
        txn_t t;
        t.rd = rd; t.res = res; t.sdata = sdata; t.rd_mem = rdm; t.wr_mem = wrm;
        t.f3 = f3; t.csr = 12'h300; t.csrw = 1'b0; t.regw = regw;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t        t;
        logic [31:0] r;
        logic [3:0]  s;
        logic [31:0] w;
        logic [31:0] bb_res [4];
        logic [2:0]  load_codes [7];
        load_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

        reset                 = 1'b0;
        is_req_valid_from_exu = 1'b0;
        rd_in_lsu             = '0;
        result_in_lsu         = '0;
        store_data_in_lsu     = '0;
        mem_read_in_lsu       = 1'b0;
        mem_write_in_lsu      = 1'b0;
        funct3_in_lsu         = '0;
        csr_addr_in_lsu       = '0;
        csr_write_in_lsu      = 1'b0;
        reg_write_in_lsu      = 1'b0;
        mem_req_ready         = 1'b0;
        mem_rsp_valid         = 1'b0;
        mem_rsp_rdata         = '0;
        mem_rsp_err           = 1'b0;
        is_req_ready_from_wbu = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        check1("rst_exu_ready", is_req_ready_to_exu, 1'b0);
        check1("rst_req_valid", mem_req_valid, 1'b0);
        check1("rst_rsp_ready", mem_rsp_ready, 1'b0);
        check1("rst_wb_valid", is_req_valid_to_wbu, 1'b0);
        check32("rst_result", result_out_lsu, 32'h0);
        check32("rst_wstrb", 32'(mem_wstrb), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1 check1("rel_exu_ready", is_req_ready_to_exu, 1'b1);

        // ALU op
        t = mk(5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        run_txn(t, 0, 0, 0, 32'h0, 1'b0, 1'b0, r, s, w);
        check32("alu_result", r, 32'h1234);

        // Back-to-back ALU packets with WBU always ready
        @(negedge clock);
        is_req_ready_from_wbu = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                @(negedge clock);
            end
            if (k < 4) begin
                bb_res[k]             = $urandom;
                is_req_valid_from_exu = 1'b1;
                rd_in_lsu             = 5'(k + 1);
                result_in_lsu         = bb_res[k];
                mem_read_in_lsu       = 1'b0;
                mem_write_in_lsu      = 1'b0;
                reg_write_in_lsu      = 1'b1;
            end else begin
                is_req_valid_from_exu = 1'b0;
            end
            #1;
            check1("bb_exu_ready", is_req_ready_to_exu, 1'b1);
            if (k > 0) begin
                check1("bb_wb_valid", is_req_valid_to_wbu, 1'b1);
                check32("bb_result", result_out_lsu, bb_res[k-1]);
                check32("bb_rd", 32'(rd_out_lsu), 32'(k));
                check1("bb_fwd", is_data_forward_valid_from_lsu, 1'b1);
            end
        end
        @(negedge clock);
        is_req_ready_from_wbu = 1'b0;
        #1 check1("bb_drain", is_req_valid_to_wbu, 1'b0);

        // lb / lbu at a top byte lane
        t = mk(5'd7, 32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1);
        run_txn(t, 1, 1, 0, 32'h80FF_FFFF, 1'b0, 1'b0, r, s, w);
        check32("lb_result", r, 32'hFFFF_FF80);
        t.f3 = 3'd4;
        run_txn(t, 0, 0, 0, 32'h80FF_FFFF, 1'b0, 1'b0, r, s, w);
        check32("lbu_result", r, 32'h0000_0080);

        // sh with delayed request acceptance
        t = mk(5'd0, 32'h8000_0102, 32'h0000_BEEF, 1'b0, 1'b1, 3'd1, 1'b0);
        run_txn(t, 3, 0, 0, 32'h0, 1'b0, 1'b0, r, s, w);
        check32("sh_wstrb", 32'(s), 32'hC);
        check32("sh_wdata", w, 32'hBEEF_BEEF);

        // Misaligned lw, then lw with bus error
        t = mk(5'd9, 32'h8000_0002, 32'h0, 1'b1, 1'b0, 3'd2, 1'b1);
        run_txn(t, 0, 0, 0, 32'h0, 1'b0, 1'b0, r, s, w);
        t.res = 32'h8000_0004;
        run_txn(t, 0, 2, 0, 32'h1234_5678, 1'b1, 1'b0, r, s, w);

        // WBU stalls for 4 cycles
        t = mk(5'd3, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        t.csrw = 1'b1;
        run_txn(t, 0, 0, 4, 32'h0, 1'b0, 1'b0, r, s, w);

        // Response arriving in the request-handshake cycle is ignored
        t = mk(5'd11, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 3'd2, 1'b1);
        run_txn(t, 1, 1, 0, 32'h0BAD_C0DE, 1'b0, 1'b1, r, s, w);

        // Reset while waiting in RSP
        @(negedge clock);
        is_req_valid_from_exu = 1'b1;
        result_in_lsu         = 32'h0000_0100;
        mem_read_in_lsu       = 1'b1;
        mem_write_in_lsu      = 1'b0;
        funct3_in_lsu         = 3'd2;
        reg_write_in_lsu      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        is_req_valid_from_exu = 1'b0;
        mem_req_ready         = 1'b1;
        @(posedge clock);
        @(negedge clock);
        mem_req_ready = 1'b0;
        #1 check1("mid_rsp_ready", mem_rsp_ready, 1'b1);
        reset = 1'b0;
        #1;
        check1("mid_rst_rsp_ready", mem_rsp_ready, 1'b0);
        check1("mid_rst_req_valid", mem_req_valid, 1'b0);
        check1("mid_rst_wb_valid", is_req_valid_to_wbu, 1'b0);
        check1("mid_rst_exu_ready", is_req_ready_to_exu, 1'b0);
        @(negedge clock);
        reset         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hDEAD_BEEF;
        #1;
        check1("post_rst_exu_ready", is_req_ready_to_exu, 1'b1);
        check1("post_rst_rsp_ready", mem_rsp_ready, 1'b0);
        @(posedge clock);
        @(negedge clock);
        mem_rsp_valid = 1'b0;
        #1;
        check1("stray_no_wb", is_req_valid_to_wbu, 1'b0);
        check1("stray_idle", is_req_ready_to_exu, 1'b1);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind    = $urandom_range(0, 2);
            t.rd    = 5'($urandom);
            t.res   = $urandom;
            t.sdata = $urandom;
            t.csr   = 12'($urandom);
            t.csrw  = 1'($urandom);
            t.rd_mem = (kind == 1);
            t.wr_mem = (kind == 2);
            if (kind == 1) begin
                t.f3   = load_codes[$urandom_range(0, 6)];
                t.regw = 1'b1;
            end else if (kind == 2) begin
                t.f3   = 3'($urandom_range(0, 2));
                t.regw = 1'b0;
            end else begin
                t.f3   = 3'($urandom);
                t.regw = 1'($urandom);
            end
            run_txn(t, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                    r, s, w);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
